id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- Pipeline register between the decode stage (control_unit, register file, immediate generator) and the execute stage of the RV64 core.
- On every non-stalled clock, captures the decoded control bundle (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp) together with the operands, immediate, register indices, ALU-control function bits and PC.
- Supports a hold (stall) for load-use hazards and a bubble insert (flush) for taken branches.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- XLEN, 64, datapath width (PC, operands, immediate).
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold all outputs this cycle.
- flush  input  1  load a bubble this cycle.
- id_valid  input  1  decode stage holds a real instruction.
- id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch  input  1 each  control_unit outputs.
- id_ALUOp  input  2  control_unit ALUOp.
- id_pc  input  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  input  XLEN each  register file read data.
- id_imm  input  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  input  REG_ADDR_W each  register indices.
- id_funct3  input  3  instruction bits [14:12].
- id_funct7b5  input  1  instruction bit 30.
- ex_valid  output  1  registered valid.
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch  output  1 each  registered control.
- ex_ALUOp  output  2  registered ALUOp.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN each  registered data.
- ex_rs1, ex_rs2, ex_rd  output  REG_ADDR_W each  registered indices.
- ex_funct3  output  3  registered funct3.
- ex_funct7b5  output  1  registered funct7 bit 5.
- bubble_cnt  output  CNT_W  saturating count of flush-inserted bubbles.

Behaviour:
- Reset: reset=1 asynchronously forces every output, including bubble_cnt, to 0, regardless of clk. Outputs stay 0 while reset is held. The first capture occurs on the first rising edge after reset deasserts.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N; no combinational path from input to output.
- Per-edge priority is flush > stall > load.
- Flush (flush=1, regardless of stall): all ex_* outputs load 0 (ex_valid=0, all control 0, ALUOp=00, data/indices 0). bubble_cnt increments by 1 and holds at all-ones once saturated, with no wrap.
- Stall (stall=1, flush=0): every output holds its current value. bubble_cnt is unchanged.
- Load (stall=0, flush=0): ex_valid <= id_valid. Data, index, funct and PC fields load their id_* values unconditionally.
- Valid gating on load: each control output loads id_<sig> AND id_valid, and ex_ALUOp loads id_ALUOp only when id_valid=1, otherwise 00. An invalid decode slot therefore never produces RegWrite, MemWrite or Branch in EX, even when control_unit decodes a non-zero opcode.
- A load of id_valid=0 does not increment bubble_cnt; only flush cycles are counted.
- Opcode 0000000 (NULL) decodes to all-zero control, so a valid NULL instruction passes as a harmless no-op with ex_valid=1.
- Reset asserted mid-stall or mid-flush overrides immediately. No stall or flush state persists past reset.

Test Plan:
- Reset: drive random inputs, assert reset between clock edges -> all outputs 0 immediately (before the next edge). Deassert; next edge with id_valid=1, R-type controls (RegWrite=1, ALUOp=10), id_rd=5 -> ex_RegWrite=1, ex_ALUOp=10, ex_rd=5 after one edge.
- Load path: ld with id_MemRead=1, MemtoReg=1, ALUSrc=1, ALUOp=00, id_imm=0x10, id_rs1_data=0x1000 -> next cycle ex_MemRead=1, ex_MemtoReg=1, ex_ALUSrc=1, ex_imm=0x10, ex_rs1_data=0x1000, ex_valid=1.
- Stall: capture sd (MemWrite=1, id_rs2_data=0xDEAD); then stall=1 for 3 edges while inputs change to beq -> outputs remain the sd values (ex_MemWrite=1, ex_Branch=0) for all 3 cycles. Release -> beq values appear (ex_Branch=1, ex_ALUOp=01).
- Flush and simultaneous flush+stall: flush=1 with addi inputs -> all outputs 0, bubble_cnt=1. Next edge with flush=1 and stall=1 -> outputs 0, bubble_cnt=2.
- Invalid slot: id_valid=0 with id_RegWrite=1, id_MemWrite=1, id_ALUOp=10 -> ex_valid=0, ex_RegWrite=0, ex_MemWrite=0, ex_ALUOp=00, bubble_cnt unchanged.
- Saturation: with CNT_W=2, apply 5 consecutive flushes -> bubble_cnt reads 1, 2, 3, 3, 3. Assert reset -> bubble_cnt=0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the RV64 core: captures decoded control and operands,
// with stall (hold), flush (bubble) and a saturating bubble counter.
module id_ex_pipe_reg #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic                  id_RegWrite,
    input  logic                  id_MemRead,
    input  logic                  id_MemWrite,
    input  logic                  id_MemtoReg,
    input  logic                  id_ALUSrc,
    input  logic                  id_Branch,
    input  logic [1:0]            id_ALUOp,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [2:0]            id_funct3,
    input  logic                  id_funct7b5,
    output logic                  ex_valid,
    output logic                  ex_RegWrite,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite,
    output logic                  ex_MemtoReg,
    output logic                  ex_ALUSrc,
    output logic                  ex_Branch,
    output logic [1:0]            ex_ALUOp,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [2:0]            ex_funct3,
    output logic                  ex_funct7b5,
    output logic [CNT_W-1:0]      bubble_cnt
);

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  memto_reg;
        logic                  alu_src;
        logic                  branch;
        logic [1:0]            alu_op;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic                  funct7b5;
    } ex_bundle_t;

    ex_bundle_t       ex_d, ex_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        // NOTE: defaulting every always_comb target to its held value first keeps this latch-free.
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            ex_d = '0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (!stall) begin
            ex_d.valid     = id_valid;
            ex_d.pc        = id_pc;
            ex_d.rs1_data  = id_rs1_data;
            ex_d.rs2_data  = id_rs2_data;
            ex_d.imm       = id_imm;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.rd        = id_rd;
            ex_d.funct3    = id_funct3;
            ex_d.funct7b5  = id_funct7b5;
            // An empty decode slot must never carry side-effecting control into EX.
            ex_d.reg_write = id_RegWrite & id_valid;
            ex_d.mem_read  = id_MemRead  & id_valid;
            ex_d.mem_write = id_MemWrite & id_valid;
            ex_d.memto_reg = id_MemtoReg & id_valid;
            ex_d.alu_src   = id_ALUSrc   & id_valid;
            ex_d.branch    = id_Branch   & id_valid;
            ex_d.alu_op    = id_valid ? id_ALUOp : 2'b00;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_RegWrite = ex_q.reg_write;
    assign ex_MemRead  = ex_q.mem_read;
    assign ex_MemWrite = ex_q.mem_write;
    assign ex_MemtoReg = ex_q.memto_reg;
    assign ex_ALUSrc   = ex_q.alu_src;
    assign ex_Branch   = ex_q.branch;
    assign ex_ALUOp    = ex_q.alu_op;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_funct3   = ex_q.funct3;
    assign ex_funct7b5 = ex_q.funct7b5;
    assign bubble_cnt  = bubble_cnt_q;

endmodule
